// File: rtl/uart_frame_pkg.sv
// Constants shared by the IGBT command frame parser and the reply frame transmitter:
// header bytes, length byte, byte positions within a frame and FSM state encodings.
package uart_frame_pkg;

  localparam logic [7:0] HEAD0     = 8'hAF;
  localparam logic [7:0] HEAD1     = 8'hFA;
  localparam logic [7:0] FRAME_LEN = 8'd9;

  localparam logic [3:0] IDX_HEAD0  = 4'd0;
  localparam logic [3:0] IDX_HEAD1  = 4'd1;
  localparam logic [3:0] IDX_LEN    = 4'd2;
  localparam logic [3:0] IDX_STATUS = 4'd3;
  localparam logic [3:0] IDX_CH     = 4'd4;
  localparam logic [3:0] IDX_CM     = 4'd5;
  localparam logic [3:0] IDX_CL     = 4'd6;
  localparam logic [3:0] IDX_DH     = 4'd7;
  localparam logic [3:0] IDX_DM     = 4'd8;
  localparam logic [3:0] IDX_DL     = 4'd9;
  localparam logic [3:0] IDX_CKH    = 4'd10;
  localparam logic [3:0] IDX_CKL    = 4'd11;
  localparam logic [3:0] IDX_LAST   = 4'd11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd2;
  localparam logic [2:0] ST_STROBE    = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/uart_ack_frame_tx.sv
// Reply frame transmitter: latches a reply request, builds the 12-byte checksummed frame and
// feeds it byte-by-byte into uart_send via send_en/send_data/tx_busy.
module uart_ack_frame_tx
  import uart_frame_pkg::*;
#(
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ack_req,
  input  logic [7:0]  ack_status,
  input  logic [23:0] ack_charge_time,
  input  logic [23:0] ack_discharge_time,
  input  logic        tx_busy,
  output logic        send_en,
  output logic [7:0]  send_data,
  output logic        ack_busy,
  output logic        ack_done,
  output logic        ack_err
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  status_q, status_d;
  logic [23:0] charge_q, charge_d;
  logic [23:0] discharge_q, discharge_d;
  logic [15:0] csum_q, csum_d;
  logic        send_en_q, send_en_d;
  logic [7:0]  send_data_q, send_data_d;
  logic        ack_busy_q, ack_busy_d;
  logic        ack_done_q, ack_done_d;
  logic        ack_err_q, ack_err_d;

  logic [15:0] csum_calc;
  logic [7:0]  frame_byte;

  // Sum of bytes LEN..DL, each zero-extended.
  always_comb begin
    csum_calc = {8'd0, FRAME_LEN}
              + {8'd0, status_q}
              + {8'd0, charge_q[23:16]}
              + {8'd0, charge_q[15:8]}
              + {8'd0, charge_q[7:0]}
              + {8'd0, discharge_q[23:16]}
              + {8'd0, discharge_q[15:8]}
              + {8'd0, discharge_q[7:0]};
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      IDX_HEAD0:  frame_byte = HEAD0;
      IDX_HEAD1:  frame_byte = HEAD1;
      IDX_LEN:    frame_byte = FRAME_LEN;
      IDX_STATUS: frame_byte = status_q;
      IDX_CH:     frame_byte = charge_q[23:16];
      IDX_CM:     frame_byte = charge_q[15:8];
      IDX_CL:     frame_byte = charge_q[7:0];
      IDX_DH:     frame_byte = discharge_q[23:16];
      IDX_DM:     frame_byte = discharge_q[15:8];
      IDX_DL:     frame_byte = discharge_q[7:0];
      IDX_CKH:    frame_byte = csum_q[15:8];
      IDX_CKL:    frame_byte = csum_q[7:0];
      default:    frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    charge_d    = charge_q;
    discharge_d = discharge_q;
    csum_d      = csum_q;
    send_en_d   = send_en_q;
    send_data_d = send_data_q;
    ack_busy_d  = ack_busy_q;
    ack_done_d  = 1'b0;
    ack_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ack_req) begin
          status_d    = ack_status;
          charge_d    = ack_charge_time;
          discharge_d = ack_discharge_time;
          ack_busy_d  = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        csum_d  = csum_calc;
        idx_d   = 4'd0;
        state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        // Waiting for tx_busy to drop guarantees a low gap on send_en between bytes.
        if (!tx_busy) begin
          send_data_d = frame_byte;
          send_en_d   = 1'b1;
          state_d     = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          send_en_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          // Abort so that send_en has been high for exactly BUSY_TIMEOUT cycles.
          if (cnt_d == BUSY_TIMEOUT - 16'd1) begin
            send_en_d  = 1'b0;
            ack_err_d  = 1'b1;
            ack_busy_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        ack_done_d = 1'b1;
        ack_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        send_en_d  = 1'b0;
        ack_busy_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= 16'd0;
      status_q    <= 8'd0;
      charge_q    <= 24'd0;
      discharge_q <= 24'd0;
      csum_q      <= 16'd0;
      send_en_q   <= 1'b0;
      send_data_q <= 8'd0;
      ack_busy_q  <= 1'b0;
      ack_done_q  <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      charge_q    <= charge_d;
      discharge_q <= discharge_d;
      csum_q      <= csum_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
      ack_busy_q  <= ack_busy_d;
      ack_done_q  <= ack_done_d;
      ack_err_q   <= ack_err_d;
    end
  end

  assign send_en   = send_en_q;
  assign send_data = send_data_q;
  assign ack_busy  = ack_busy_q;
  assign ack_done  = ack_done_q;
  assign ack_err   = ack_err_q;

endmodule

// File: doc/uart_ack_frame_tx.md
Name: uart_ack_frame_tx

Overview:
- Downstream companion of the IGBT command frame parser.
- Accepts a one-cycle reply request carrying status and the echoed charge/discharge times.
- Builds a fixed 12-byte reply frame with a 16-bit checksum and streams it byte-by-byte into the existing uart_send stage over its send_en/send_data/tx_busy handshake.
- Reports completion or a handshake timeout to the control logic.

Parameters:
- HEAD0, 8'hAF, first frame header byte.
- HEAD1, 8'hFA, second frame header byte.
- FRAME_LEN, 8'd9, length byte value: bytes following LEN (status + 6 time bytes + 2 checksum bytes).
- BUSY_TIMEOUT, 16'd1000, max sys_clk cycles send_en may stay high waiting for tx_busy to rise.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; synchronous, active-low.
- ack_req  in  1  one-cycle reply request, sampled only in IDLE.
- ack_status  in  8  status byte.
- ack_charge_time  in  24  charge time, sent MSB byte first.
- ack_discharge_time  in  24  discharge time, sent MSB byte first.
- tx_busy  in  1  busy flag from uart_send.
- send_en  out  1  byte strobe to uart_send (rising edge launches a byte).
- send_data  out  8  byte to uart_send.
- ack_busy  out  1  high from request accept until DONE/abort.
- ack_done  out  1  one-cycle pulse after the last byte is accepted.
- ack_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0, state IDLE, byte index 0, timeout counter 0. Reset is sampled on the sys_clk edge only and overrides everything, including mid-frame. The next frame after reset restarts at HEAD0.
- Frame byte order, index 0..11: HEAD0, HEAD1, FRAME_LEN, status, CH, CM, CL, DH, DM, DL, CKH, CKL.
- Checksum: 16-bit unsigned sum of bytes 2..9, each byte zero-extended, modulo 2^16. The maximum is 0x0702, so it never wraps in practice; the adder is still 16 bits wide.
- FSM states: IDLE, LOAD, WAIT_IDLE, STROBE, WAIT_BUSY, DONE.
- IDLE:
  - If ack_req=1, latch all fields into registers and go to LOAD; ack_busy <= 1.
  - If ack_req=0, stay in IDLE.
- LOAD: compute and register the checksum; index <= 0; go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay while tx_busy=1.
  - When tx_busy=0, send_data <= byte[index], send_en <= 1, go to STROBE.
- STROBE: timeout counter <= 0; go to WAIT_BUSY. send_en remains 1.
- WAIT_BUSY:
  - On tx_busy=1: send_en <= 0.
    - If index==11, go to DONE.
    - Otherwise index++ and go to WAIT_IDLE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1: send_en <= 0, ack_err <= 1 for one cycle, ack_busy <= 0, go to IDLE. The partial frame is abandoned.
- DONE: ack_done <= 1 for one cycle, ack_busy <= 0, go to IDLE.
- send_en low gap: because WAIT_IDLE requires tx_busy to fall, send_en is guaranteed low for at least one cycle between bytes, so each byte gives uart_send a clean rising edge.
- send_data: holds the last driven byte between strobes.
- Latency: with tx_busy=0, ack_req at edge n gives first send_en=1 at edge n+3 (IDLE, LOAD, WAIT_IDLE).
- ack_req outside IDLE (including the DONE cycle) is ignored, not queued. Input fields are don't-care except in the accepting cycle.
- tx_busy already high when the frame starts: the block waits in WAIT_IDLE indefinitely. The timeout applies only in WAIT_BUSY.

Decomposition:
- Shared package uart_frame_pkg: HEAD0/HEAD1 constants, FRAME_LEN, frame byte-index constants (IDX_LEN, IDX_STATUS, IDX_CKH, IDX_CKL, IDX_LAST=11), FSM state encoding. The parser uses the same header, length and index constants.
- No sub-module. The byte mux and checksum adder stay inline.

Test Plan:
- Basic frame. Stimulus: status=01, charge=000064, discharge=0000C8; tx model raises tx_busy 2 cycles after each send_en rise and holds it 20 cycles. Required: bytes AF FA 09 01 00 00 64 00 00 C8 01 36 in order, exactly 12 send_en rises, one ack_done pulse, ack_err never set.
- Max checksum. Stimulus: status=FF, all time bytes FF. Required: checksum bytes 07 02.
- Line busy at request. Stimulus: tx_busy held high for 50 cycles at the request. Required: send_en stays 0 until tx_busy falls; the first byte AF is driven within 1 cycle after that.
- Timeout. Stimulus: tx_busy never rises. Required: send_en high for exactly BUSY_TIMEOUT cycles, then ack_err pulses once, ack_busy falls, and ack_done does not pulse.
- Request handling. Stimulus: ack_req pulsed mid-frame (ignored), then again one cycle after ack_done. Required: the mid-frame request produces no second frame; the post-done request produces a full second frame.
- Reset mid-frame. Stimulus: sys_rst_n low at the edge during byte 5. Required: all outputs 0 on the next edge; a new request restarts the frame at AF.
